// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache/memory arbiter: one-hot FSM encodings,
// requester ids, line offset width and request type codes.
package cache_arb_pkg;

  localparam int LINE_OFF_W = 4;

  localparam logic ID_DCACHE = 1'b0;
  localparam logic ID_ICACHE = 1'b1;

  localparam logic [2:0] TYPE_BYTE = 3'd0;
  localparam logic [2:0] TYPE_HALF = 3'd1;
  localparam logic [2:0] TYPE_WORD = 3'd2;
  localparam logic [2:0] TYPE_LINE = 3'd4;

  typedef enum logic [2:0] {
    R_IDLE = 3'b001,
    R_REQ  = 3'b010,
    R_RET  = 3'b100
  } rd_state_e;

  typedef enum logic [2:0] {
    W_IDLE = 3'b001,
    W_REQ  = 3'b010,
    W_WAIT = 3'b100
  } wr_state_e;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of icache, dcache and memory-side request/return signals around the arbiter.
// Modport master is the arbiter's view; slave is the caches plus the memory bridge.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  logic              i_rd_req,    d_rd_req;
  logic [2:0]        i_rd_type,   d_rd_type;
  logic [ADDR_W-1:0] i_rd_addr,   d_rd_addr;
  logic              i_rd_rdy,    d_rd_rdy;
  logic              i_ret_valid, d_ret_valid;
  logic              i_ret_last,  d_ret_last;
  logic [31:0]       i_ret_data,  d_ret_data;

  logic              d_wr_req;
  logic [2:0]        d_wr_type;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [3:0]        d_wr_wstrb;
  logic [LINE_W-1:0] d_wr_data;
  logic              d_wr_rdy;

  logic              m_rd_req;
  logic [2:0]        m_rd_type;
  logic [ADDR_W-1:0] m_rd_addr;
  logic              m_rd_id;
  logic              m_rd_rdy;
  logic              m_ret_valid, m_ret_last;
  logic [31:0]       m_ret_data;

  logic              m_wr_req;
  logic [2:0]        m_wr_type;
  logic [ADDR_W-1:0] m_wr_addr;
  logic [3:0]        m_wr_wstrb;
  logic [LINE_W-1:0] m_wr_data;
  logic              m_wr_rdy;
  logic              m_wr_done;

  modport master (
    input  i_rd_req, i_rd_type, i_rd_addr, d_rd_req, d_rd_type, d_rd_addr,
    output i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
    output d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
    input  d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
    output d_wr_rdy,
    output m_rd_req, m_rd_type, m_rd_addr, m_rd_id,
    input  m_rd_rdy, m_ret_valid, m_ret_last, m_ret_data,
    output m_wr_req, m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data,
    input  m_wr_rdy, m_wr_done
  );

  modport slave (
    output i_rd_req, i_rd_type, i_rd_addr, d_rd_req, d_rd_type, d_rd_addr,
    input  i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
    input  d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
    output d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
    input  d_wr_rdy,
    input  m_rd_req, m_rd_type, m_rd_addr, m_rd_id,
    output m_rd_rdy, m_ret_valid, m_ret_last, m_ret_data,
    input  m_wr_req, m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data,
    output m_wr_rdy, m_wr_done
  );
endinterface

// File: rtl/cache_arb_wbuf.sv
// One-entry dcache writeback buffer: captures a write, issues it to memory, waits for
// the write response, and reports per-requester line matches against the buffered write.
module cache_arb_wbuf
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_wr_req,
  input  logic [2:0]             i_wr_type,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic [3:0]             i_wr_wstrb,
  input  logic [LINE_W-1:0]      i_wr_data,
  input  logic                   i_mem_wr_rdy,
  input  logic                   i_mem_wr_done,
  input  logic [1:0][ADDR_W-1:0] i_cmp_addr,
  output logic [1:0]             o_wbuf_hit_line,
  output logic                   o_wr_rdy,
  output logic                   o_mem_wr_req,
  output logic [2:0]             o_mem_wr_type,
  output logic [ADDR_W-1:0]      o_mem_wr_addr,
  output logic [3:0]             o_mem_wr_wstrb,
  output logic [LINE_W-1:0]      o_mem_wr_data
);

  wr_state_e         r_state, w_state_next;
  logic [2:0]        r_type;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_wstrb;
  logic [LINE_W-1:0] r_data;
  logic              w_capture;

  assign w_capture = (r_state == W_IDLE) && i_wr_req;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= W_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_type  <= '0;
      r_addr  <= '0;
      r_wstrb <= '0;
      r_data  <= '0;
    end else if (w_capture) begin
      r_type  <= i_wr_type;
      r_addr  <= i_wr_addr;
      r_wstrb <= i_wr_wstrb;
      r_data  <= i_wr_data;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_wr_rdy     = 1'b0;
    o_mem_wr_req = 1'b0;
    case (r_state)
      W_IDLE: begin
        o_wr_rdy = 1'b1;
        if (i_wr_req) w_state_next = W_REQ;
      end
      W_REQ: begin
        o_mem_wr_req = 1'b1;
        if (i_mem_wr_rdy) w_state_next = W_WAIT;
      end
      W_WAIT:  if (i_mem_wr_done) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  assign o_mem_wr_type  = r_type;
  assign o_mem_wr_addr  = r_addr;
  assign o_mem_wr_wstrb = r_wstrb;
  assign o_mem_wr_data  = r_data;

  // A write being captured this cycle already blocks reads to its line.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hit
      assign o_wbuf_hit_line[gi] =
          ((r_state != W_IDLE) &&
           (r_addr[ADDR_W-1:LINE_OFF_W] == i_cmp_addr[gi][ADDR_W-1:LINE_OFF_W])) ||
          (w_capture &&
           (i_wr_addr[ADDR_W-1:LINE_OFF_W] == i_cmp_addr[gi][ADDR_W-1:LINE_OFF_W]));
    end
  endgenerate

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the memory port between icache and dcache: one outstanding read, a one-entry
// write buffer, and read blocking on buffered-line match. ARB_ROUND_ROBIN_EN selects round-robin.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic                clk,
  input  logic                resetn,
  cache_mem_arbiter_if.master bus
);

  rd_state_e                r_rd_state, w_rd_state_next;
  logic                     r_rd_id;
  logic [2:0]               r_rd_type;
  logic [ADDR_W-1:0]        r_rd_addr;
  logic [1:0]               w_req, w_hit, w_elig;
  logic [1:0][ADDR_W-1:0]   w_cmp_addr;
  logic                     w_prefer_i, w_pick_i, w_grant, w_ret_d, w_ret_i;

  // Bit index equals requester id: bit 0 dcache, bit 1 icache.
  assign w_req      = {bus.i_rd_req, bus.d_rd_req};
  assign w_cmp_addr = {bus.i_rd_addr, bus.d_rd_addr};
  assign w_elig     = w_req & ~w_hit;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      r_last_grant <= ID_ICACHE;
    else if (w_grant) r_last_grant <= w_pick_i;
  end
  assign w_prefer_i = (r_last_grant == ID_DCACHE);
`else
  assign w_prefer_i = 1'b0;
`endif

  assign w_pick_i = w_elig[ID_ICACHE] && (!w_elig[ID_DCACHE] || w_prefer_i);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rd_state <= R_IDLE;
    else         r_rd_state <= w_rd_state_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_id   <= ID_DCACHE;
      r_rd_type <= '0;
      r_rd_addr <= '0;
    end else if (w_grant) begin
      r_rd_id   <= w_pick_i;
      r_rd_type <= w_pick_i ? bus.i_rd_type : bus.d_rd_type;
      r_rd_addr <= w_pick_i ? bus.i_rd_addr : bus.d_rd_addr;
    end
  end

  always_comb begin
    w_rd_state_next = r_rd_state;
    w_grant         = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (|w_elig) begin
          w_grant         = 1'b1;
          w_rd_state_next = R_REQ;
        end
      end
      R_REQ:   if (bus.m_rd_rdy) w_rd_state_next = R_RET;
      R_RET:   if (bus.m_ret_valid && bus.m_ret_last) w_rd_state_next = R_IDLE;
      default: w_rd_state_next = R_IDLE;
    endcase
  end

  assign bus.d_rd_rdy  = w_grant && !w_pick_i;
  assign bus.i_rd_rdy  = w_grant && w_pick_i;
  assign bus.m_rd_req  = (r_rd_state == R_REQ);
  assign bus.m_rd_type = r_rd_type;
  assign bus.m_rd_addr = r_rd_addr;
  assign bus.m_rd_id   = r_rd_id;

  // Return beats reach only the owner of the outstanding read.
  assign w_ret_d = (r_rd_state == R_RET) && (r_rd_id == ID_DCACHE);
  assign w_ret_i = (r_rd_state == R_RET) && (r_rd_id == ID_ICACHE);

  assign bus.d_ret_valid = w_ret_d && bus.m_ret_valid;
  assign bus.d_ret_last  = w_ret_d && bus.m_ret_valid && bus.m_ret_last;
  assign bus.d_ret_data  = w_ret_d ? bus.m_ret_data : '0;
  assign bus.i_ret_valid = w_ret_i && bus.m_ret_valid;
  assign bus.i_ret_last  = w_ret_i && bus.m_ret_valid && bus.m_ret_last;
  assign bus.i_ret_data  = w_ret_i ? bus.m_ret_data : '0;

  cache_arb_wbuf #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_wbuf (
    .clk             (clk),
    .resetn          (resetn),
    .i_wr_req        (bus.d_wr_req),
    .i_wr_type       (bus.d_wr_type),
    .i_wr_addr       (bus.d_wr_addr),
    .i_wr_wstrb      (bus.d_wr_wstrb),
    .i_wr_data       (bus.d_wr_data),
    .i_mem_wr_rdy    (bus.m_wr_rdy),
    .i_mem_wr_done   (bus.m_wr_done),
    .i_cmp_addr      (w_cmp_addr),
    .o_wbuf_hit_line (w_hit),
    .o_wr_rdy        (bus.d_wr_rdy),
    .o_mem_wr_req    (bus.m_wr_req),
    .o_mem_wr_type   (bus.m_wr_type),
    .o_mem_wr_addr   (bus.m_wr_addr),
    .o_mem_wr_wstrb  (bus.m_wr_wstrb),
    .o_mem_wr_data   (bus.m_wr_data)
  );

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios then random traffic, every cycle checked
// against a transaction-level model of grants, the outstanding read and the write buffer.
module tb_cache_mem_arbiter;
  import cache_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 none / 1 awaiting memory accept / 2 returning (read);
  // 0 empty / 1 awaiting memory accept / 2 awaiting response (write buffer).
  int          rphase = 0, wphase = 0;
  bit          m_owner_i = 0, m_last_i = 1;
  logic [31:0] m_raddr = '0, m_waddr = '0;
  logic [2:0]  m_rtype = '0, m_wtype = '0;
  logic [3:0]  m_wstrb = '0;
  logic [127:0] m_wdata = '0;
  bit          g_d = 0, g_i = 0, g_w = 0;
  bit          rand_mode = 0;

  function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
    return a[31:4] == b[31:4];
  endfunction

  function automatic bit blocked(input logic [31:0] a);
    return (wphase != 0 && same_line(a, m_waddr)) ||
           (wphase == 0 && bus.d_wr_req && same_line(a, bus.d_wr_addr));
  endfunction

  function automatic bit quiet();
    return !bus.d_rd_req && !bus.i_rd_req && !bus.d_wr_req && rphase == 0 && wphase == 0;
  endfunction

  initial begin : monitor
    bit d_ok, i_ok, prefer_d, e_d, e_i, dv, iv;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        rphase = 0; wphase = 0; m_last_i = 1; g_d = 0; g_i = 0; g_w = 0;
        check_eq("rst_d_rd_rdy", bus.d_rd_rdy, 0);
        check_eq("rst_i_rd_rdy", bus.i_rd_rdy, 0);
        check_eq("rst_m_rd_req", bus.m_rd_req, 0);
        check_eq("rst_m_wr_req", bus.m_wr_req, 0);
        check_eq("rst_d_wr_rdy", bus.d_wr_rdy, 1);
        continue;
      end
      d_ok = bus.d_rd_req && !blocked(bus.d_rd_addr);
      i_ok = bus.i_rd_req && !blocked(bus.i_rd_addr);
`ifdef ARB_ROUND_ROBIN_EN
      prefer_d = m_last_i;
`else
      prefer_d = 1'b1;
`endif
      e_d = (rphase == 0) && d_ok && (prefer_d || !i_ok);
      e_i = (rphase == 0) && i_ok && !e_d;
      check_eq("d_rd_rdy", bus.d_rd_rdy, e_d);
      check_eq("i_rd_rdy", bus.i_rd_rdy, e_i);
      check_eq("m_rd_req", bus.m_rd_req, rphase == 1);
      if (rphase == 1) begin
        check_eq("m_rd_addr", bus.m_rd_addr, m_raddr);
        check_eq("m_rd_type", bus.m_rd_type, m_rtype);
        check_eq("m_rd_id", bus.m_rd_id, m_owner_i);
      end
      dv = (rphase == 2) && !m_owner_i && bus.m_ret_valid;
      iv = (rphase == 2) && m_owner_i && bus.m_ret_valid;
      check_eq("d_ret_valid", bus.d_ret_valid, dv);
      check_eq("i_ret_valid", bus.i_ret_valid, iv);
      check_eq("d_ret_last", bus.d_ret_last, dv && bus.m_ret_last);
      check_eq("i_ret_last", bus.i_ret_last, iv && bus.m_ret_last);
      if (dv) check_eq("d_ret_data", bus.d_ret_data, bus.m_ret_data);
      if (iv) check_eq("i_ret_data", bus.i_ret_data, bus.m_ret_data);
      check_eq("d_wr_rdy", bus.d_wr_rdy, wphase == 0);
      check_eq("m_wr_req", bus.m_wr_req, wphase == 1);
      if (wphase == 1) begin
        check_eq("m_wr_addr", bus.m_wr_addr, m_waddr);
        check_eq("m_wr_type", bus.m_wr_type, m_wtype);
        check_eq("m_wr_wstrb", bus.m_wr_wstrb, m_wstrb);
        check_eq("m_wr_data", bus.m_wr_data, m_wdata);
      end
      g_d = bus.d_rd_rdy;
      g_i = bus.i_rd_rdy;
      g_w = bus.d_wr_req && bus.d_wr_rdy;
      // Advance the model to what the coming clock edge commits.
      if (e_d || e_i) begin
        rphase = 1; m_owner_i = e_i; m_last_i = e_i;
        m_raddr = e_i ? bus.i_rd_addr : bus.d_rd_addr;
        m_rtype = e_i ? bus.i_rd_type : bus.d_rd_type;
      end else if (rphase == 1 && bus.m_rd_rdy) begin
        rphase = 2;
      end else if (rphase == 2 && bus.m_ret_valid && bus.m_ret_last) begin
        rphase = 0;
        $display("RD  id=%0d addr=%h type=%0d t=%0t", m_owner_i, m_raddr, m_rtype, $time);
      end
      if (wphase == 0 && bus.d_wr_req) begin
        wphase = 1; m_waddr = bus.d_wr_addr; m_wtype = bus.d_wr_type;
        m_wstrb = bus.d_wr_wstrb; m_wdata = bus.d_wr_data;
      end else if (wphase == 1 && bus.m_wr_rdy) begin
        wphase = 2;
      end else if (wphase == 2 && bus.m_wr_done) begin
        wphase = 0;
        $display("WR  addr=%h strb=%h t=%0t", m_waddr, m_wstrb, $time);
      end
    end
  end

  // Memory-side responder with random handshakes and occasional spurious pulses.
  initial begin : memory
    int beats, wr_delay;
    bit wr_pend;
    beats = 0; wr_delay = 0; wr_pend = 0;
    bus.m_rd_rdy = 0; bus.m_ret_valid = 0; bus.m_ret_last = 0; bus.m_ret_data = '0;
    bus.m_wr_rdy = 0; bus.m_wr_done = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        beats = 0; wr_pend = 0; wr_delay = 0;
      end else begin
        if (bus.m_rd_req && bus.m_rd_rdy) beats = (bus.m_rd_type == TYPE_LINE) ? 4 : 1;
        else if (beats > 0 && bus.m_ret_valid) beats--;
        if (bus.m_wr_req && bus.m_wr_rdy) begin
          wr_pend = 1; wr_delay = int'($urandom_range(3, 0));
        end else if (wr_pend && bus.m_wr_done) wr_pend = 0;
        else if (wr_pend && wr_delay > 0) wr_delay--;
      end
      @(posedge clk); #1;
      bus.m_rd_rdy   = ($urandom % 2) == 0;
      bus.m_ret_data = $urandom;
      if (beats > 0) begin
        bus.m_ret_valid = ($urandom % 4) != 0;
        bus.m_ret_last  = (beats == 1);
      end else begin
        bus.m_ret_valid = ($urandom % 8) == 0;
        bus.m_ret_last  = ($urandom % 2) == 0;
      end
      bus.m_wr_rdy  = ($urandom % 2) == 0;
      bus.m_wr_done = wr_pend ? (wr_delay == 0) : (($urandom % 10) == 0);
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] base;
    case ($urandom % 4)
      0:       base = 32'h0000_1000;
      1:       base = 32'h0000_1010;
      2:       base = 32'h1C00_0000;
      default: base = 32'h0000_2000;
    endcase
    return base | ($urandom % 16);
  endfunction

  function automatic logic [2:0] rand_type();
    case ($urandom % 4)
      0:       return TYPE_BYTE;
      1:       return TYPE_HALF;
      2:       return TYPE_WORD;
      default: return TYPE_LINE;
    endcase
  endfunction

  task automatic set_write(input logic [31:0] addr);
    bus.d_wr_req   = 1;
    bus.d_wr_addr  = addr;
    bus.d_wr_type  = ($urandom % 2) ? TYPE_LINE : TYPE_WORD;
    bus.d_wr_wstrb = 4'($urandom);
    bus.d_wr_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic set_read(input bit icache, input logic [31:0] addr, input logic [2:0] t);
    if (icache) begin
      bus.i_rd_req = 1; bus.i_rd_addr = addr; bus.i_rd_type = t;
    end else begin
      bus.d_rd_req = 1; bus.d_rd_addr = addr; bus.d_rd_type = t;
    end
  endtask

  // One clock: requests drop after their accept, random mode issues fresh ones.
  task automatic cyc();
    @(posedge clk); #1;
    if (g_d) bus.d_rd_req = 0;
    if (g_i) bus.i_rd_req = 0;
    if (g_w) bus.d_wr_req = 0;
    if (rand_mode) begin
      if (!bus.d_rd_req && ($urandom % 3) == 0) set_read(0, rand_addr(), rand_type());
      if (!bus.i_rd_req && ($urandom % 3) == 0) set_read(1, rand_addr(), rand_type());
      if (!bus.d_wr_req && ($urandom % 5) == 0) set_write(rand_addr());
    end
  endtask

  task automatic wait_quiet(input int limit, input string tag);
    int n = 0;
    while (!quiet() && n < limit) begin
      cyc();
      n++;
    end
    check_eq(tag, quiet(), 1);
  endtask

  task automatic wait_ret(input int limit, input string tag);
    int n = 0;
    while (rphase != 2 && n < limit) begin
      cyc();
      n++;
    end
    check_eq(tag, rphase == 2, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=running exp=finished t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.i_rd_req = 0; bus.i_rd_type = '0; bus.i_rd_addr = '0;
    bus.d_rd_req = 0; bus.d_rd_type = '0; bus.d_rd_addr = '0;
    bus.d_wr_req = 0; bus.d_wr_type = '0; bus.d_wr_addr = '0;
    bus.d_wr_wstrb = '0; bus.d_wr_data = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;

    set_read(1, 32'h1C00_0000, TYPE_LINE);
    wait_quiet(100, "icache_line_read_done");

    for (int r = 0; r < 2; r++) begin
      set_read(0, 32'h0000_2000, TYPE_LINE);
      set_read(1, 32'h0000_3000, TYPE_LINE);
      wait_quiet(200, "both_req_done");
    end

    set_write(32'h0000_1230);
    set_read(0, 32'h0000_1238, TYPE_LINE);
    set_read(1, 32'h0000_1240, TYPE_LINE);
    wait_quiet(300, "blocked_read_done");

    set_read(0, 32'h0000_4000, TYPE_LINE);
    wait_ret(100, "reach_ret_for_write");
    set_write(32'h0000_5000);
    wait_quiet(200, "write_during_ret_done");

    set_read(1, 32'h1C00_0010, TYPE_LINE);
    wait_ret(100, "reach_ret_for_reset");
    resetn = 0;
    bus.i_rd_req = 0; bus.d_rd_req = 0; bus.d_wr_req = 0;
    #1;
    check_eq("arst_i_rd_rdy", bus.i_rd_rdy, 0);
    check_eq("arst_d_rd_rdy", bus.d_rd_rdy, 0);
    check_eq("arst_i_ret_valid", bus.i_ret_valid, 0);
    check_eq("arst_d_ret_valid", bus.d_ret_valid, 0);
    check_eq("arst_i_ret_last", bus.i_ret_last, 0);
    check_eq("arst_i_ret_data", bus.i_ret_data, 0);
    check_eq("arst_m_rd_req", bus.m_rd_req, 0);
    check_eq("arst_m_rd_addr", bus.m_rd_addr, 0);
    check_eq("arst_m_rd_id", bus.m_rd_id, 0);
    check_eq("arst_m_wr_req", bus.m_wr_req, 0);
    check_eq("arst_d_wr_rdy", bus.d_wr_rdy, 1);
    repeat (2) cyc();
    resetn = 1;
    set_read(0, 32'h0000_6004, TYPE_WORD);
    wait_quiet(100, "read_after_reset_done");

    rand_mode = 1;
    repeat (2000) cyc();
    rand_mode = 0;
    wait_quiet(500, "random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
